pulse_meter: RTL and testbench

- Downstream consumer of the edge detector's one-cycle `rising_edge_o`/`falling_edge_o` pulses.
- Measures the high-pulse width of the detected signal in clock cycles.
- Counts accepted rising edges.
- Delivers each width measurement through a single-entry valid/ready output register to a downstream sink (CSR block or logger).

---
 rtl/pulse_meter.sv | 149 ++++++++++++++
 tb/tb_pulse_meter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_meter.sv
// High-pulse width meter fed by edge-detector pulses, with a one-entry valid/ready result register.
// Optional PULSE_METER_PERIOD_EN adds a rise-to-rise period reported alongside each width.
module pulse_meter #(
  parameter int CNT_W     = 16,
  parameter int MIN_WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             rising_edge_i,
  input  logic             falling_edge_i,
  output logic [CNT_W-1:0] width_o,
  output logic             width_sat_o,
  output logic             width_valid_o,
  input  logic             width_ready_i,
  output logic             drop_o,
  output logic [CNT_W-1:0] edge_cnt_o
`ifdef PULSE_METER_PERIOD_EN
  ,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o
`endif
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_WIDTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             done;
  logic             rise_acc, fall_acc, both_edges;
  logic             keep, reg_free, load, drop_d, xfer;

  // Simultaneous edges cancel; nothing is accepted while disabled.
  assign both_edges = rising_edge_i & falling_edge_i;
  assign rise_acc   = en_i & rising_edge_i & ~falling_edge_i;
  assign fall_acc   = en_i & falling_edge_i & ~rising_edge_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    done    = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
    end else if (rise_acc) begin
      state_d = MEASURE;
      cnt_d   = CNT_W'(1);
      sat_d   = 1'b0;
    end else if (state_q == MEASURE) begin
      if (fall_acc) begin
        state_d = IDLE;
        done    = 1'b1;
      end else if (!both_edges) begin
        cnt_d = sat_inc(cnt_q);
        sat_d = sat_q | (cnt_q == CNT_MAX);
      end
    end
  end

  // The register is free if empty or being drained in this same cycle.
  assign xfer     = width_valid_o & width_ready_i;
  assign reg_free = ~width_valid_o | width_ready_i;
  assign keep     = done & (cnt_q >= MIN_W);
  assign load     = keep & reg_free;
  assign drop_d   = keep & ~reg_free;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sat_q         <= 1'b0;
      width_o       <= '0;
      width_sat_o   <= 1'b0;
      width_valid_o <= 1'b0;
      drop_o        <= 1'b0;
      edge_cnt_o    <= '0;
    end else if (clr_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sat_q         <= 1'b0;
      width_o       <= '0;
      width_sat_o   <= 1'b0;
      width_valid_o <= 1'b0;
      drop_o        <= 1'b0;
      edge_cnt_o    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      drop_o     <= drop_d;
      edge_cnt_o <= edge_cnt_o + CNT_W'(rise_acc);
      if (load) begin
        width_o       <= cnt_q;
        width_sat_o   <= sat_q;
        width_valid_o <= 1'b1;
      end else if (xfer) begin
        width_valid_o <= 1'b0;
      end
    end
  end

`ifdef PULSE_METER_PERIOD_EN
  logic [CNT_W-1:0] per_cnt_q, pend_q;
  logic             prev_ok_q, pend_vld_q;

  // prev_ok_q marks that a rise has been seen since reset/clear/enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_cnt_q      <= '0;
      pend_q         <= '0;
      prev_ok_q      <= 1'b0;
      pend_vld_q     <= 1'b0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
    end else if (clr_i) begin
      per_cnt_q      <= '0;
      pend_q         <= '0;
      prev_ok_q      <= 1'b0;
      pend_vld_q     <= 1'b0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
    end else begin
      if (rise_acc) begin
        per_cnt_q  <= CNT_W'(1);
        pend_q     <= per_cnt_q;
        pend_vld_q <= prev_ok_q;
        prev_ok_q  <= 1'b1;
      end else begin
        per_cnt_q <= sat_inc(per_cnt_q);
        if (!en_i) prev_ok_q <= 1'b0;
      end
      if (load) begin
        period_o       <= pend_q;
        period_valid_o <= pend_vld_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter (CNT_W=4, MIN_WIDTH=2): directed literal checks plus randomized
// stimulus compared every cycle against an unbounded-integer behavioural model.
module tb_pulse_meter;
  localparam int CW   = 4;
  localparam int MINW = 2;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, en, clr, rise, fall, ready;
  logic [CW-1:0] width_o, edge_cnt_o;
  logic          width_sat_o, width_valid_o, drop_o;
`ifdef PULSE_METER_PERIOD_EN
  logic [CW-1:0] period_o;
  logic          period_valid_o;
`endif

  int checks = 0;
  int errors = 0;

  pulse_meter #(.CNT_W(CW), .MIN_WIDTH(MINW)) dut (
    .clk(clk), .reset(reset), .en_i(en), .clr_i(clr),
    .rising_edge_i(rise), .falling_edge_i(fall),
    .width_o(width_o), .width_sat_o(width_sat_o), .width_valid_o(width_valid_o),
    .width_ready_i(ready), .drop_o(drop_o), .edge_cnt_o(edge_cnt_o)
`ifdef PULSE_METER_PERIOD_EN
    , .period_o(period_o), .period_valid_o(period_valid_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pulse length kept as an unbounded integer, clipped on delivery.
  bit m_meas, m_valid, m_sat, m_drop, m_have, m_pend_v, m_pv;
  int m_w, m_edge, m_width, m_pctr, m_pend, m_per;
  bit rise_ok, fall_ok;

  task automatic model_clear();
    m_meas = 0; m_valid = 0; m_sat = 0; m_drop = 0; m_have = 0;
    m_pend_v = 0; m_pv = 0; m_w = 0; m_edge = 0; m_width = 0;
    m_pctr = 0; m_pend = 0; m_per = 0;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset || clr) begin
      model_clear();
    end else begin
      rise_ok = en && rise && !fall;
      fall_ok = en && fall && !rise;
      m_drop  = 0;
      if (m_valid && ready) m_valid = 0;
      if (rise_ok) begin
        m_pend   = (m_pctr > MAXV) ? MAXV : m_pctr;
        m_pend_v = m_have;
        m_have   = 1;
        m_pctr   = 1;
      end else begin
        m_pctr++;
        if (!en) m_have = 0;
      end
      if (!en) begin
        m_meas = 0;
      end else if (rise_ok) begin
        m_meas = 1;
        m_w    = 1;
        m_edge++;
      end else if (m_meas && fall_ok) begin
        m_meas = 0;
        if (m_w >= MINW) begin
          if (!m_valid) begin
            m_valid = 1;
            m_width = (m_w > MAXV) ? MAXV : m_w;
            m_sat   = (m_w > MAXV);
            m_per   = m_pend;
            m_pv    = m_pend_v;
          end else begin
            m_drop = 1;
          end
        end
      end else if (m_meas && !(rise && fall)) begin
        m_w++;
      end
    end
  end

  always @(negedge clk) begin
    check("valid", width_valid_o, m_valid);
    check("drop", drop_o, m_drop);
    check("edge_cnt", edge_cnt_o, m_edge % (MAXV + 1));
    if (m_valid) begin
      check("width", width_o, m_width);
      check("width_sat", width_sat_o, m_sat);
`ifdef PULSE_METER_PERIOD_EN
      check("period", period_o, m_per);
      check("period_valid", period_valid_o, m_pv);
`endif
    end
  end

  // Rise sampled at edge t, fall at edge t+n; returns at the negedge where the result shows.
  task automatic pulse(input int n);
    rise = 1; @(negedge clk); rise = 0;
    repeat (n - 1) @(negedge clk);
    fall = 1; @(negedge clk); fall = 0;
  endtask

  task automatic expect_zero(input string tag);
    check({tag, "_valid"}, width_valid_o, 0);
    check({tag, "_width"}, width_o, 0);
    check({tag, "_sat"}, width_sat_o, 0);
    check({tag, "_drop"}, drop_o, 0);
    check({tag, "_edge"}, edge_cnt_o, 0);
`ifdef PULSE_METER_PERIOD_EN
    check({tag, "_pvalid"}, period_valid_o, 0);
`endif
  endtask

  int rate;

  initial begin
    reset = 0; en = 0; clr = 0; rise = 0; fall = 0; ready = 1;
    repeat (2) @(negedge clk);
    expect_zero("reset");
    reset = 1; en = 1;
    @(negedge clk);

    pulse(5);
    check("t1_width", width_o, 5);
    check("t1_sat", width_sat_o, 0);
    check("t1_valid", width_valid_o, 1);
    check("t1_edge", edge_cnt_o, 1);
    @(negedge clk);
    check("t1_drained", width_valid_o, 0);

    pulse(20);
    check("sat_width", width_o, 15);
    check("sat_flag", width_sat_o, 1);
    @(negedge clk);

    ready = 0;
    pulse(3);
    check("hold_width", width_o, 3);
    repeat (2) @(negedge clk);
    pulse(7);
    check("drop_pulse", drop_o, 1);
    check("drop_held_width", width_o, 3);
    @(negedge clk);
    check("drop_one_cycle", drop_o, 0);
    check("drop_still_valid", width_valid_o, 1);
    ready = 1;
    @(negedge clk);
    check("drop_drained", width_valid_o, 0);

    pulse(1);
    check("short_valid", width_valid_o, 0);
    check("short_drop", drop_o, 0);
    pulse(2);
    check("min_width", width_o, 2);
    check("min_valid", width_valid_o, 1);
    @(negedge clk);
    rise = 1; fall = 1; @(negedge clk); rise = 0; fall = 0;
    check("both_edge_cnt", edge_cnt_o, 6);
    fall = 1; @(negedge clk); fall = 0; @(negedge clk);
    check("idle_fall_valid", width_valid_o, 0);

    rise = 1; @(negedge clk); rise = 0;
    repeat (3) @(negedge clk);
    en = 0; @(negedge clk);
    en = 1; fall = 1; @(negedge clk); fall = 0; @(negedge clk);
    check("en_abort_valid", width_valid_o, 0);
    check("en_abort_edge", edge_cnt_o, 7);

    ready = 0;
    pulse(3);
    check("clr_pre_valid", width_valid_o, 1);
    clr = 1; @(negedge clk); clr = 0;
    expect_zero("clr");
    ready = 1;

`ifdef PULSE_METER_PERIOD_EN
    pulse(4);
    check("per1_width", width_o, 4);
    check("per1_pvalid", period_valid_o, 0);
    repeat (7) @(negedge clk);
    pulse(6);
    check("per2_width", width_o, 6);
    check("per2_period", period_o, 12);
    check("per2_pvalid", period_valid_o, 1);
    repeat (11) @(negedge clk);
    pulse(3);
    check("per3_period", period_o, 18);
`endif

    ready = 0;
    pulse(3);
    rise = 1; @(negedge clk); rise = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    reset = 0; #1;
    expect_zero("async");
    @(negedge clk);
    reset = 1; ready = 1;
    @(negedge clk);

    for (int blk = 0; blk < 8; blk++) begin
      rate = (blk % 2 == 1) ? 4 : 24;
      for (int c = 0; c < 500; c++) begin
        rise  = ($urandom_range(0, rate - 1) == 0);
        fall  = ($urandom_range(0, rate - 1) == 0);
        en    = ($urandom_range(0, 49) != 0);
        ready = $urandom_range(0, 1);
        clr   = ($urandom_range(0, 199) == 0);
        @(negedge clk);
      end
    end
    rise = 0; fall = 0; clr = 0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
